aes_roundkey_sched: RTL and testbench
=====================================

# aes_roundkey_sched

Registered front/back end for the combinational round-key generator. It latches a cipher key and mode and drives them into the generator. After a programmable settle time it captures the generator's 15 round keys into local storage. It then streams the keys one per beat over a valid/ready interface to the iterative round datapath: ascending order for encryption, descending order for decryption.

## Interface
- `SETTLE_CYCLES`, default 2: cycles allowed for the generator's combinational chain before capture (multicycle path); legal range 1..15.

- `clk` in 1: clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `key_load` in 1: load request; samples `key_in` and `mode_in`.
- `key_in` in 256: cipher key. AES-128 key in [255:128]; AES-192 key in [255:64]; AES-256 key in [255:0].
- `mode_in` in 2: 00 = AES-128, 01 = AES-192, 10 = AES-256, 11 = illegal.
- `gen_key` out 256: registered key driven to the generator.
- `gen_mode` out 2: registered mode driven to the generator.
- `gen_round_key` in 128 x [14:0]: round keys returned by the generator.
- `key_ready` out 1: valid key schedule is stored.
- `err_mode` out 1: one-cycle pulse when `key_load` is rejected for `mode_in` = 11.
- `start` in 1: begin streaming.
- `decrypt` in 1: sampled with `start`; 1 = descending order.
- `busy` out 1: high during SETTLE or STREAM.
- `rk_valid` out 1: round-key beat is valid.
- `rk_ready` in 1: consumer accepts the beat.
- `rk_data` out 128: round key.
- `rk_index` out 4: round number of `rk_data`.
- `rk_last` out 1: final beat of the stream.
- `zeroize` in 1: present only under `AES_RK_ZEROIZE_EN`.

## Operation
- Nr = 10, 12 or 14 for mode 00, 01 or 10. The stream carries Nr+1 keys, indices 0..Nr.
- Reset value of every output register is 0: `gen_key`, `gen_mode`, `key_ready`, `err_mode`, `busy`, `rk_valid`, `rk_data`, `rk_index`, `rk_last`. Stored keys are also 0. State resets to IDLE.
- States and transitions:
  - IDLE: no valid schedule. A legal `key_load` goes to SETTLE.
  - SETTLE: the settle counter is loaded with `SETTLE_CYCLES` and decrements once per cycle. At count 0, all 15 `gen_round_key` entries are captured, `key_ready` is set, and the state goes to READY.
  - READY: `start` goes to STREAM. A legal `key_load` goes to SETTLE and clears `key_ready`.
  - STREAM: beats advance on `rk_valid && rk_ready`. After the handshake with `rk_last` high, the state goes to READY.
- Encrypt order: index 0 up to Nr; `rk_last` when index = Nr. Decrypt order: index Nr down to 0; `rk_last` when index = 0.
- `rk_data` always equals stored key[`rk_index`]. `rk_valid` stays high until the handshake (AXI-style); `rk_data` and `rk_index` are stable while `rk_valid && !rk_ready`.
- `key_load` with `mode_in` = 11: ignored, `err_mode` pulses, state and `key_ready` are unchanged.
- `key_load` during SETTLE: new key and mode are latched and the counter restarts.
- `key_load` during STREAM: ignored. The stream completes with the old keys.
- `start` outside READY is ignored. `start` and `key_load` in the same READY cycle: `key_load` wins.
- Asynchronous reset mid-stream: `rk_valid` drops immediately, `key_ready` = 0, state IDLE.

## Timing
- `gen_key` and `gen_mode` update on the edge that samples `key_load`.
- `key_ready` rises `SETTLE_CYCLES`+1 edges after the `key_load` edge.
- `start` sampled at edge t: `rk_valid` high with the first beat after edge t. The 1-cycle latency is fixed.
- With `rk_ready` held high, one beat per cycle: Nr+1 consecutive cycles, no bubbles.
- `busy` and `key_ready` are registered, with no combinational paths from inputs. `rk_valid` does not depend combinationally on `rk_ready`.

## Configuration
- `AES_RK_ZEROIZE_EN` defined: `zeroize` port exists.
  - A high `zeroize` sampled at an edge clears stored keys, `gen_key`, `gen_mode` and all outputs to reset values, and returns the state to IDLE.
  - It has priority over `key_load` and `start`, and aborts a stream without `rk_last`.
- `AES_RK_ZEROIZE_EN` undefined: the port is absent. Stored keys persist until the next legal load or reset.

## Test plan
- AES-128, key 000102030405060708090a0b0c0d0e0f, encrypt, `rk_ready` = 1 -> 11 beats, index 0..10; beat 0 = 000102…0f; beat 10 = 13111d7fe3944a17f307a78b4d2b30c5 with `rk_last`.
- AES-256, key 000102…1f, decrypt -> 15 beats, first beat index 14 = 24fc79ccbf0979e9371ac23c6d68de36, last beat index 0 = 000102…0f.
- `rk_ready` toggling 1010… during an AES-128 stream -> no beat duplicated or skipped, and data is held while stalled.
- `mode_in` = 11 on `key_load` in READY -> `err_mode` pulses one cycle, `key_ready` stays 1, next stream matches the previous key.
- `key_load` issued during STREAM, then `rst_n` asserted mid-stream -> stream completes with old keys; reset zeroes all outputs asynchronously.
- Under `AES_RK_ZEROIZE_EN`: `zeroize` at beat 3 -> `rk_valid` = 0 next cycle, `key_ready` = 0, a following `start` is ignored.

Source files
------------

// File: rtl/aes_roundkey_sched.sv
// Registered front/back end for the combinational AES round-key generator: latches key/mode,
// captures the 15 round keys after a settle window and streams them. Zeroize via AES_RK_ZEROIZE_EN.
module aes_roundkey_sched #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_load,
   input  logic [255:0]       key_in,
   input  logic [1:0]         mode_in,
   output logic [255:0]       gen_key,
   output logic [1:0]         gen_mode,
   input  logic [14:0][127:0] gen_round_key,
   output logic               key_ready,
   output logic               err_mode,
   input  logic               start,
   input  logic               decrypt,
   output logic               busy,
   output logic               rk_valid,
   input  logic               rk_ready,
   output logic [127:0]       rk_data,
   output logic [3:0]         rk_index,
   output logic               rk_last,
`ifdef AES_RK_ZEROIZE_EN
   input  logic               zeroize,
`endif
   output logic [1:0]         dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_READY  = 2'd2,
      ST_STREAM = 2'd3
   } state_t;

   localparam logic [3:0] LP_SETTLE = 4'(SETTLE_CYCLES);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [255:0]       r_gen_key;
   logic [1:0]         r_gen_mode;
   logic [3:0]         r_settle_cnt;
   logic [14:0][127:0] r_keys;
   logic               r_decrypt;
   logic               r_key_ready;
   logic               r_err_mode;
   logic               r_busy;
   logic               r_rk_valid;
   logic               r_rk_last;
   logic [3:0]         r_rk_index;

   logic               w_zeroize;
   logic               w_load_legal;
   logic               w_load_bad;
   logic               w_load_ok;
   logic               w_start_ok;
   logic               w_settle_done;
   logic               w_handshake;
   logic [3:0]         w_nr;
   logic [3:0]         w_first_idx;
   logic [3:0]         w_step_idx;
   logic               w_key_ready_nxt;
   logic               w_err_mode_nxt;
   logic               w_busy_nxt;
   logic               w_rk_valid_nxt;
   logic               w_rk_last_nxt;
   logic [3:0]         w_rk_index_nxt;

`ifdef AES_RK_ZEROIZE_EN
   assign w_zeroize = zeroize;
`else
   assign w_zeroize = 1'b0;
`endif

   // A load is refused outright for the illegal mode, and silently while a stream is in flight.
   assign w_load_legal  = key_load && (mode_in != 2'b11);
   assign w_load_bad    = key_load && (mode_in == 2'b11);
   assign w_load_ok     = w_load_legal && (r_state != ST_STREAM);
   assign w_start_ok    = start && (r_state == ST_READY) && !w_load_ok;
   assign w_settle_done = (r_state == ST_SETTLE) && (r_settle_cnt == 4'd0) && !w_load_ok;
   // Valid/ready: a beat transfers on a rising edge where rk_valid && rk_ready; rk_valid is
   // registered, never withdrawn before that edge, and rk_index/rk_data hold while stalled.
   assign w_handshake   = r_rk_valid && rk_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_zeroize) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_load_ok) w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
               if (w_load_ok)          w_state_nxt = ST_SETTLE;
               else if (w_settle_done) w_state_nxt = ST_READY;
            end
            ST_READY: begin
               if (w_load_ok)       w_state_nxt = ST_SETTLE;
               else if (w_start_ok) w_state_nxt = ST_STREAM;
            end
            ST_STREAM: begin
               if (w_handshake && r_rk_last) w_state_nxt = ST_READY;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      w_nr            = (r_gen_mode == 2'b00) ? 4'd10 : (r_gen_mode == 2'b01) ? 4'd12 : 4'd14;
      w_first_idx     = decrypt ? w_nr : 4'd0;
      w_step_idx      = r_decrypt ? (r_rk_index - 4'd1) : (r_rk_index + 4'd1);
      w_busy_nxt      = (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_STREAM);
      w_key_ready_nxt = (w_state_nxt == ST_READY) || (w_state_nxt == ST_STREAM);
      w_err_mode_nxt  = w_load_bad && !w_zeroize;
      w_rk_valid_nxt  = r_rk_valid;
      w_rk_index_nxt  = r_rk_index;
      w_rk_last_nxt   = r_rk_last;
      if (w_zeroize) begin
         w_rk_valid_nxt = 1'b0;
         w_rk_index_nxt = 4'd0;
         w_rk_last_nxt  = 1'b0;
      end else if (w_start_ok) begin
         w_rk_valid_nxt = 1'b1;
         w_rk_index_nxt = w_first_idx;
         w_rk_last_nxt  = decrypt ? (w_first_idx == 4'd0) : (w_first_idx == w_nr);
      end else if (w_handshake) begin
         if (r_rk_last) begin
            w_rk_valid_nxt = 1'b0;
            w_rk_last_nxt  = 1'b0;
         end else begin
            w_rk_index_nxt = w_step_idx;
            w_rk_last_nxt  = r_decrypt ? (w_step_idx == 4'd0) : (w_step_idx == w_nr);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_ready <= 1'b0;
         r_err_mode  <= 1'b0;
         r_busy      <= 1'b0;
         r_rk_valid  <= 1'b0;
         r_rk_index  <= 4'd0;
         r_rk_last   <= 1'b0;
      end else begin
         r_key_ready <= w_key_ready_nxt;
         r_err_mode  <= w_err_mode_nxt;
         r_busy      <= w_busy_nxt;
         r_rk_valid  <= w_rk_valid_nxt;
         r_rk_index  <= w_rk_index_nxt;
         r_rk_last   <= w_rk_last_nxt;
      end
   end

   // The generator output is only sampled once the counter has run out (multicycle path).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_gen_key    <= '0;
         r_gen_mode   <= 2'b00;
         r_settle_cnt <= 4'd0;
         r_keys       <= '0;
         r_decrypt    <= 1'b0;
      end else if (w_zeroize) begin
         r_gen_key    <= '0;
         r_gen_mode   <= 2'b00;
         r_settle_cnt <= 4'd0;
         r_keys       <= '0;
         r_decrypt    <= 1'b0;
      end else begin
         if (w_load_ok) begin
            r_gen_key    <= key_in;
            r_gen_mode   <= mode_in;
            r_settle_cnt <= LP_SETTLE;
         end else if ((r_state == ST_SETTLE) && (r_settle_cnt != 4'd0)) begin
            r_settle_cnt <= r_settle_cnt - 4'd1;
         end
         if (w_settle_done) r_keys <= gen_round_key;
         if (w_start_ok) r_decrypt <= decrypt;
      end
   end

   assign gen_key   = r_gen_key;
   assign gen_mode  = r_gen_mode;
   assign key_ready = r_key_ready;
   assign err_mode  = r_err_mode;
   assign busy      = r_busy;
   assign rk_valid  = r_rk_valid;
   assign rk_index  = r_rk_index;
   assign rk_last   = r_rk_last;
   assign rk_data   = (r_rk_index > 4'd14) ? '0 : r_keys[r_rk_index];
   assign dbg_state = r_state;

endmodule

// File: tb/tb_aes_roundkey_sched.sv
// Directed bench for aes_roundkey_sched; a behavioural AES key expansion stands in for the
// combinational generator. Zeroize scenario is compiled in with AES_RK_ZEROIZE_EN.
module tb_aes_roundkey_sched;
  localparam int SETTLE = 2;
  localparam logic [255:0] K128 = 256'h000102030405060708090a0b0c0d0e0f_a5a5a5a5_5a5a5a5a_c3c3c3c3_3c3c3c3c;
  localparam logic [255:0] K192 = 256'h000102030405060708090a0b0c0d0e0f1011121314151617_0123456789abcdef;
  localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] R_LOW   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] R128_10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R256_14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               key_load = 1'b0;
  logic [255:0]       key_in = '0;
  logic [1:0]         mode_in = 2'b00;
  logic [255:0]       gen_key;
  logic [1:0]         gen_mode;
  logic [14:0][127:0] gen_rk = '0;
  logic               key_ready;
  logic               err_mode;
  logic               start = 1'b0;
  logic               decrypt = 1'b0;
  logic               busy;
  logic               rk_valid;
  logic               rk_ready = 1'b0;
  logic [127:0]       rk_data;
  logic [3:0]         rk_index;
  logic               rk_last;
  logic [1:0]         dbg_state;
`ifdef AES_RK_ZEROIZE_EN
  logic               zeroize = 1'b0;
`endif

  logic [7:0]         sbox [256];
  logic               sbox_ok = 1'b0;
  logic [14:0][127:0] rk192;
  int                 n_vec = 0;
  int                 n_err = 0;

  aes_roundkey_sched #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .key_load(key_load), .key_in(key_in), .mode_in(mode_in),
    .gen_key(gen_key), .gen_mode(gen_mode), .gen_round_key(gen_rk),
    .key_ready(key_ready), .err_mode(err_mode), .start(start), .decrypt(decrypt),
    .busy(busy), .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data),
    .rk_index(rk_index), .rk_last(rk_last),
`ifdef AES_RK_ZEROIZE_EN
    .zeroize(zeroize),
`endif
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
  endfunction

  // FIPS-197 key expansion; rounds beyond Nr stay zero
  function automatic logic [14:0][127:0] expand_key(input logic [255:0] k, input logic [1:0] m);
    logic [31:0]        w [60];
    logic [31:0]        t;
    logic [7:0]         rc;
    logic [14:0][127:0] r;
    int                 nk, nr;
    nk = (m == 2'b00) ? 4 : (m == 2'b01) ? 6 : 8;
    nr = nk + 6;
    r  = '0;
    rc = 8'h01;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j <= nr; j++) r[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    return r;
  endfunction

  // generator stand-in
  always @(gen_key or gen_mode or sbox_ok) gen_rk = expand_key(gen_key, gen_mode);

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (rk_valid !== 1'b0 || rk_last !== 1'b0 || rk_index !== 4'd0) begin
      n_err++; $display("FAIL reset_stream: got valid=%b last=%b idx=%0d expected 0 0 0", rk_valid, rk_last, rk_index);
    end
    n_vec++;
    if (rk_data !== 128'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", rk_data); end
    n_vec++;
    if (gen_key !== 256'h0 || gen_mode !== 2'b00) begin
      n_err++; $display("FAIL reset_gen: got key=%h mode=%b expected 0", gen_key, gen_mode);
    end
    n_vec++;
    if (key_ready !== 1'b0 || err_mode !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL reset_status: got ready=%b err=%b busy=%b st=%0d expected 0", key_ready, err_mode, busy, dbg_state);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); start = 1'b1; decrypt = 1'b0;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL idle_start: got valid=%b busy=%b st=%0d expected 0 0 0", rk_valid, busy, dbg_state);
    end
    key_load = 1'b1; mode_in = 2'b11; key_in = K128;
    @(negedge clk); key_load = 1'b0; mode_in = 2'b00;
    n_vec++;
    if (err_mode !== 1'b1 || dbg_state !== 2'd0 || gen_key !== 256'h0) begin
      n_err++; $display("FAIL idle_bad_mode: got err=%b st=%0d key=%h expected 1 0 0", err_mode, dbg_state, gen_key);
    end
  endtask

  task automatic test_load(input logic [255:0] k, input logic [1:0] m, input string name);
    @(negedge clk); key_in = k; mode_in = m; key_load = 1'b1;
    @(negedge clk); key_load = 1'b0;
    n_vec++;
    if (gen_key !== k || gen_mode !== m) begin
      n_err++; $display("FAIL %s_gen: got key=%h mode=%b expected key=%h mode=%b", name, gen_key, gen_mode, k, m);
    end
    n_vec++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_err++; $display("FAIL %s_settle: got busy=%b ready=%b expected 1 0", name, busy, key_ready);
    end
    repeat (SETTLE) @(negedge clk);
    n_vec++;
    if (key_ready !== 1'b0) begin n_err++; $display("FAIL %s_early: got ready=%b expected 0", name, key_ready); end
    @(negedge clk);
    n_vec++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL %s_ready: got ready=%b busy=%b st=%0d expected 1 0 2", name, key_ready, busy, dbg_state);
    end
  endtask

  task automatic test_stream(input logic [255:0] k, input logic [1:0] m, input logic dec,
                             input int pat, input int inject_at,
                             input logic [127:0] exp_first, input logic [127:0] exp_last,
                             input string name);
    logic [14:0][127:0] rks;
    logic [132:0]       exp_q[$];
    logic [132:0]       exp_beat;
    int                 nr, cyc, beats, idx;
    logic               rdy;
    rks = expand_key(k, m);
    nr  = (m == 2'b00) ? 10 : (m == 2'b01) ? 12 : 14;
    for (int j = 0; j <= nr; j++) begin
      idx = dec ? nr - j : j;
      exp_q.push_back({(j == nr), 4'(idx), rks[idx]});
    end
    @(negedge clk); start = 1'b1; decrypt = dec; rk_ready = 1'b0; key_in = K256; mode_in = 2'b10;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b1) begin n_err++; $display("FAIL %s_latency: got valid=%b expected 1", name, rk_valid); end
    cyc = 0; beats = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      if (rk_valid === 1'b1) begin
        exp_beat = exp_q[0];
        n_vec++;
        if ({rk_last, rk_index, rk_data} !== exp_beat) begin
          n_err++;
          $display("FAIL %s_beat%0d: got last=%b idx=%0d data=%h expected last=%b idx=%0d data=%h", name, beats,
                   rk_last, rk_index, rk_data, exp_beat[132], exp_beat[131:128], exp_beat[127:0]);
        end
      end
      rdy = (pat == 0) ? 1'b1 : (cyc % 2 == 0);
      rk_ready = rdy;
      if (inject_at >= 0) key_load = (cyc == inject_at);
      if (rk_valid === 1'b1 && rdy) begin
        if (beats == 0) begin
          n_vec++;
          if (rk_data !== exp_first) begin n_err++; $display("FAIL %s_first: got %h expected %h", name, rk_data, exp_first); end
        end
        if (beats == nr) begin
          n_vec++;
          if (rk_data !== exp_last || rk_last !== 1'b1) begin
            n_err++; $display("FAIL %s_final: got last=%b data=%h expected 1 %h", name, rk_last, rk_data, exp_last);
          end
        end
        void'(exp_q.pop_front());
        beats++;
      end
      @(negedge clk);
      cyc++;
    end
    rk_ready = 1'b0; key_load = 1'b0;
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL %s_count: got %0d beats expected %0d", name, beats, nr + 1); end
    if (pat == 0) begin
      n_vec++;
      if (cyc != nr + 1) begin n_err++; $display("FAIL %s_cycles: got %0d expected %0d", name, cyc, nr + 1); end
    end
    n_vec++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || key_ready !== 1'b1 || dbg_state !== 2'd2) begin
      n_err++; $display("FAIL %s_end: got valid=%b busy=%b ready=%b st=%0d expected 0 0 1 2", name, rk_valid, busy, key_ready, dbg_state);
    end
    n_vec++;
    if (gen_key !== k) begin n_err++; $display("FAIL %s_key_kept: got %h expected %h", name, gen_key, k); end
  endtask

  task automatic test_bad_mode();
    @(negedge clk); key_load = 1'b1; mode_in = 2'b11; key_in = K256;
    @(negedge clk); key_load = 1'b0; mode_in = 2'b00;
    n_vec++;
    if (err_mode !== 1'b1) begin n_err++; $display("FAIL bad_mode_pulse: got %b expected 1", err_mode); end
    n_vec++;
    if (key_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd2 || gen_key !== K128) begin
      n_err++; $display("FAIL bad_mode_state: got ready=%b busy=%b st=%0d key=%h expected 1 0 2 %h", key_ready, busy, dbg_state, gen_key, K128);
    end
    @(negedge clk);
    n_vec++;
    if (err_mode !== 1'b0) begin n_err++; $display("FAIL bad_mode_width: got %b expected 0", err_mode); end
  endtask

  task automatic test_priority();
    @(negedge clk); start = 1'b1; key_load = 1'b1; key_in = K256; mode_in = 2'b10;
    @(negedge clk); start = 1'b0; key_load = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || busy !== 1'b1 || key_ready !== 1'b0 || gen_mode !== 2'b10) begin
      n_err++; $display("FAIL load_wins: got valid=%b busy=%b ready=%b mode=%b expected 0 1 0 10", rk_valid, busy, key_ready, gen_mode);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || dbg_state !== 2'd1) begin
      n_err++; $display("FAIL settle_start: got valid=%b st=%0d expected 0 1", rk_valid, dbg_state);
    end
    key_load = 1'b1; key_in = K128; mode_in = 2'b00;
    @(negedge clk); key_load = 1'b0;
    repeat (SETTLE) @(negedge clk);
    n_vec++;
    if (key_ready !== 1'b0) begin n_err++; $display("FAIL settle_restart: got ready=%b expected 0", key_ready); end
    @(negedge clk);
    n_vec++;
    if (key_ready !== 1'b1 || gen_key !== K128 || gen_mode !== 2'b00) begin
      n_err++; $display("FAIL restart_ready: got ready=%b key=%h mode=%b expected 1 %h 00", key_ready, gen_key, gen_mode, K128);
    end
  endtask

  task automatic test_reset_mid_stream();
    @(negedge clk); start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if (rk_valid !== 1'b1 || rk_index !== 4'd3) begin
      n_err++; $display("FAIL pre_reset: got valid=%b idx=%0d expected 1 3", rk_valid, rk_index);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (rk_valid !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL async_reset: got valid=%b ready=%b busy=%b st=%0d expected 0", rk_valid, key_ready, busy, dbg_state);
    end
    n_vec++;
    if (gen_key !== 256'h0 || rk_data !== 128'h0 || rk_index !== 4'd0 || rk_last !== 1'b0) begin
      n_err++; $display("FAIL async_reset_data: got key=%h data=%h idx=%0d last=%b expected 0", gen_key, rk_data, rk_index, rk_last);
    end
    @(negedge clk); rst_n = 1'b1; rk_ready = 1'b0;
  endtask

`ifdef AES_RK_ZEROIZE_EN
  task automatic test_zeroize();
    int cyc;
    @(negedge clk); start = 1'b1; decrypt = 1'b0; rk_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    cyc = 0;
    while (!(rk_valid === 1'b1 && rk_index === 4'd3) && cyc < 20) begin
      @(negedge clk); cyc++;
    end
    n_vec++;
    if (cyc >= 20) begin n_err++; $display("FAIL zeroize_reach: got idx=%0d expected 3", rk_index); end
    zeroize = 1'b1;
    @(negedge clk); zeroize = 1'b0; rk_ready = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0 || rk_last !== 1'b0 || key_ready !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_err++; $display("FAIL zeroize_status: got valid=%b last=%b ready=%b busy=%b st=%0d expected 0", rk_valid, rk_last, key_ready, busy, dbg_state);
    end
    n_vec++;
    if (gen_key !== 256'h0 || rk_data !== 128'h0) begin
      n_err++; $display("FAIL zeroize_clear: got key=%h data=%h expected 0", gen_key, rk_data);
    end
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_vec++;
    if (rk_valid !== 1'b0) begin n_err++; $display("FAIL zeroize_start: got valid=%b expected 0", rk_valid); end
  endtask
`endif

  initial begin
    logic [7:0] inv;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
      sbox[a] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
    sbox_ok = 1'b1;
    rk192 = expand_key(K192, 2'b01);

    test_reset();
    test_load(K128, 2'b00, "load128");
    test_stream(K128, 2'b00, 1'b0, 0, -1, R_LOW, R128_10, "enc128");
    test_stream(K128, 2'b00, 1'b0, 1, -1, R_LOW, R128_10, "stall128");
    test_bad_mode();
    test_stream(K128, 2'b00, 1'b1, 0, -1, R128_10, R_LOW, "dec128_after_bad");
    test_load(K256, 2'b10, "load256");
    test_stream(K256, 2'b10, 1'b1, 0, -1, R256_14, R_LOW, "dec256");
    test_stream(K256, 2'b10, 1'b0, 1, -1, R_LOW, R256_14, "stall256");
    test_load(K192, 2'b01, "load192");
    test_stream(K192, 2'b01, 1'b0, 0, -1, R_LOW, rk192[12], "enc192");
    test_priority();
    test_stream(K128, 2'b00, 1'b0, 0, 3, R_LOW, R128_10, "load_in_stream");
    test_reset_mid_stream();
`ifdef AES_RK_ZEROIZE_EN
    test_load(K128, 2'b00, "load_zero");
    test_zeroize();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
